// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for one shared 8:1 single-bit mux: registered one-hot grant plus select.
// Optional per-owner hold limit with preemption when built with MUX8_MAX_HOLD_EN defined.
module mux8_rr_arbiter #(
    parameter int unsigned RESET_PTR = 0
`ifdef MUX8_MAX_HOLD_EN
    ,
    parameter int unsigned MAX_HOLD = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid
`ifdef MUX8_MAX_HOLD_EN
    ,
    output logic       preempt
`endif
);

    localparam logic StIdle  = 1'b0;
    localparam logic StOwned = 1'b1;

    logic       state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       new_grant;
    logic       release_own;
    logic       force_rel;
    logic [2:0] rel_ptr;
    logic [3:0] pick_idle;
    logic [3:0] pick_next;

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
        logic [2:0] idx;
        rr_pick = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (vec[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign rel_ptr     = sel_q + 3'd1;
    assign pick_idle   = rr_pick(req, ptr_q);
    assign pick_next   = rr_pick(req & ~gnt_q, rel_ptr);
    assign release_own = ~req[sel_q];

`ifdef MUX8_MAX_HOLD_EN
    logic [7:0] hold_q, hold_d;
    logic       preempt_q;

    // Forced release only when someone else is waiting and new grants are allowed.
    assign force_rel = en && (hold_q == 8'(MAX_HOLD - 1)) && (|(req & ~gnt_q));

    always_comb begin
        hold_d = hold_q;
        if (new_grant) begin
            hold_d = '0;
        end else if (state_q == StOwned && hold_q != 8'(MAX_HOLD - 1)) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= (state_q == StOwned) && !release_own && force_rel;
        end
    end

    assign preempt = preempt_q;
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        new_grant = 1'b0;
        case (state_q)
            StIdle: begin
                if (en && pick_idle[3]) begin
                    gnt_d     = 8'd1 << pick_idle[2:0];
                    sel_d     = pick_idle[2:0];
                    state_d   = StOwned;
                    new_grant = 1'b1;
                end
            end
            default: begin
                if (release_own || force_rel) begin
                    ptr_d = rel_ptr;
                    if (en && pick_next[3]) begin
                        gnt_d     = 8'd1 << pick_next[2:0];
                        sel_d     = pick_next[2:0];
                        new_grant = 1'b1;
                    end else begin
                        // sel keeps the last owner so the mux input stays put while idle
                        gnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 3'(RESET_PTR);
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter with hand-computed expected grants.
// Covers the MUX8_MAX_HOLD_EN hold limit when that macro is defined.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
`ifdef MUX8_MAX_HOLD_EN
    logic       preempt;
`endif

    int n_checks;
    int n_fail;

    mux8_rr_arbiter #(
        .RESET_PTR(0)
`ifdef MUX8_MAX_HOLD_EN
        ,
        .MAX_HOLD(4)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .gnt_valid(gnt_valid)
`ifdef MUX8_MAX_HOLD_EN
        ,
        .preempt  (preempt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        step();
        step();
        n_checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: gnt=%h sel=%0d gv=%b, want 00/0/0", gnt, sel, gnt_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        en  = 1'b1;
        req = 8'h10;
        step();
        n_checks++;
        if (gnt !== 8'h10 || sel !== 3'd4 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%h sel=%0d gv=%b, want 10/4/1", gnt, sel, gnt_valid);
        end
        req = 8'h00;
        step();
        n_checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd4) begin
            n_fail++;
            $display("FAIL single_release: gnt=%h sel=%0d gv=%b, want 00/4/0", gnt, sel, gnt_valid);
        end
    endtask

    // ptr is 5 here: bit 5 wins over bit 0, then the handoff wraps to 0 with no bubble.
    task automatic test_rotation();
        req = 8'h21;
        step();
        n_checks++;
        if (gnt !== 8'h20 || sel !== 3'd5) begin
            n_fail++;
            $display("FAIL rotation_first: gnt=%h sel=%0d, want 20/5", gnt, sel);
        end
        step();
        n_checks++;
        if (gnt !== 8'h20) begin
            n_fail++;
            $display("FAIL rotation_hold: gnt=%h, want 20", gnt);
        end
        req = 8'h01;
        step();
        n_checks++;
        if (gnt !== 8'h01 || sel !== 3'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation_wrap: gnt=%h sel=%0d gv=%b, want 01/0/1", gnt, sel, gnt_valid);
        end
        req = 8'h00;
        step();
        n_checks++;
        if (gnt !== 8'h00) begin
            n_fail++;
            $display("FAIL rotation_idle: gnt=%h, want 00", gnt);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_gnt;
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        step();
        for (int i = 0; i < 9; i++) begin
            exp_gnt = 8'd1 << (i % 8);
            n_checks++;
            if (gnt !== exp_gnt || sel !== 3'(i % 8) || !$onehot(gnt)) begin
                n_fail++;
                $display("FAIL fair_grant_%0d: gnt=%h sel=%0d, want %h/%0d", i, gnt, sel,
                         exp_gnt, i % 8);
            end
            req = 8'hFF;
            step();
            n_checks++;
            if (gnt !== exp_gnt) begin
                n_fail++;
                $display("FAIL fair_hold_%0d: gnt=%h, want %h", i, gnt, exp_gnt);
            end
            req = ~exp_gnt;
            step();
        end
        n_checks++;
        if (gnt !== 8'h02 || sel !== 3'd1) begin
            n_fail++;
            $display("FAIL fair_last: gnt=%h sel=%0d, want 02/1", gnt, sel);
        end
        req = 8'h00;
        step();
    endtask

    // ptr is 2 on entry; request 3 alone to make it the owner.
    task automatic test_enable();
        en  = 1'b1;
        req = 8'h08;
        step();
        n_checks++;
        if (gnt !== 8'h08 || sel !== 3'd3) begin
            n_fail++;
            $display("FAIL en_owner: gnt=%h sel=%0d, want 08/3", gnt, sel);
        end
        en  = 1'b0;
        req = 8'h88;
        step();
        n_checks++;
        if (gnt !== 8'h08) begin
            n_fail++;
            $display("FAIL en_keep: gnt=%h, want 08", gnt);
        end
        req = 8'h80;
        step();
        n_checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_release: gnt=%h gv=%b, want 00/0", gnt, gnt_valid);
        end
        step();
        n_checks++;
        if (gnt !== 8'h00) begin
            n_fail++;
            $display("FAIL en_blocked: gnt=%h, want 00", gnt);
        end
        en = 1'b1;
        step();
        n_checks++;
        if (gnt !== 8'h80 || sel !== 3'd7) begin
            n_fail++;
            $display("FAIL en_resume: gnt=%h sel=%0d, want 80/7", gnt, sel);
        end
        req = 8'h00;
        step();
    endtask

    // ptr is 0: owner 1 then idle leaves ptr at 2; owner 2 drops and re-requests.
    task automatic test_rerequest();
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        req = 8'h05;
        step();
        n_checks++;
        if (gnt !== 8'h04) begin
            n_fail++;
            $display("FAIL rereq_owner: gnt=%h, want 04", gnt);
        end
        req = 8'h01;
        step();
        n_checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL rereq_switch: gnt=%h sel=%0d, want 01/0", gnt, sel);
        end
        req = 8'h05;
        step();
        n_checks++;
        if (gnt !== 8'h01) begin
            n_fail++;
            $display("FAIL rereq_ignore: gnt=%h, want 01", gnt);
        end
        req = 8'h04;
        step();
        n_checks++;
        if (gnt !== 8'h04 || sel !== 3'd2) begin
            n_fail++;
            $display("FAIL rereq_back: gnt=%h sel=%0d, want 04/2", gnt, sel);
        end
        req = 8'h00;
        step();
    endtask

    // Leave ptr at 3 before the reset so a restart from RESET_PTR is observable.
    task automatic test_async_reset();
        req = 8'h04;
        step();
        n_checks++;
        if (gnt !== 8'h04) begin
            n_fail++;
            $display("FAIL areset_pre: gnt=%h, want 04", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async: gnt=%h sel=%0d gv=%b, want 00/0/0", gnt, sel, gnt_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h81;
        step();
        n_checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_restart: gnt=%h sel=%0d, want 01/0", gnt, sel);
        end
        req = 8'h00;
        step();
    endtask

`ifdef MUX8_MAX_HOLD_EN
    task automatic test_max_hold();
        do_reset();
        en  = 1'b1;
        req = 8'h44;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gnt !== 8'h04 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: gnt=%h pre=%b, want 04/0", i, gnt, preempt);
            end
            step();
        end
        n_checks++;
        if (gnt !== 8'h40 || sel !== 3'd6 || preempt !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_preempt: gnt=%h sel=%0d pre=%b, want 40/6/1", gnt, sel, preempt);
        end
        step();
        n_checks++;
        if (gnt !== 8'h40 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_pulse: gnt=%h pre=%b, want 40/0", gnt, preempt);
        end
        do_reset();
        en  = 1'b1;
        req = 8'h04;
        step();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (gnt !== 8'h04 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_alone_%0d: gnt=%h pre=%b, want 04/0", i, gnt, preempt);
            end
            step();
        end
        req = 8'h00;
        step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_fairness();
        test_enable();
        test_rerequest();
        test_async_reset();
`ifdef MUX8_MAX_HOLD_EN
        test_max_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
